// File: rtl/scramble_pkg.sv
// scramble_pkg: scancode map, key bit indices and autofire constants for the PS/2 key decoder
package scramble_pkg;
    localparam logic [2:0] IDX_UP     = 3'd0;
    localparam logic [2:0] IDX_DOWN   = 3'd1;
    localparam logic [2:0] IDX_LEFT   = 3'd2;
    localparam logic [2:0] IDX_RIGHT  = 3'd3;
    localparam logic [2:0] IDX_FIRE   = 3'd4;
    localparam logic [2:0] IDX_BOMB   = 3'd5;
    localparam logic [2:0] IDX_START  = 3'd6;
    localparam logic [2:0] IDX_SELECT = 3'd7;
    localparam logic [8:0] SC_UP     = 9'h175;
    localparam logic [8:0] SC_DOWN   = 9'h172;
    localparam logic [8:0] SC_LEFT   = 9'h16B;
    localparam logic [8:0] SC_RIGHT  = 9'h174;
    localparam logic [8:0] SC_FIRE   = 9'h014;
    localparam logic [8:0] SC_BOMB   = 9'h011;
    localparam logic [8:0] SC_START  = 9'h016;
    localparam logic [8:0] SC_SELECT = 9'h01E;
    localparam logic [4:0] AF_BASE = 5'd16;
    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } key_evt_t;
endpackage

// File: rtl/scramble_keymap.sv
// scramble_keymap: combinational {extended, scancode} to keys bit index lookup
module scramble_keymap
    import scramble_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic       hit,
    output logic [2:0] idx
);
    logic [8:0] k;
    assign k = {ext, code};
    always_comb begin
        {hit, idx} = k == SC_UP     ? {1'b1, IDX_UP}     :
                     k == SC_DOWN   ? {1'b1, IDX_DOWN}   :
                     k == SC_LEFT   ? {1'b1, IDX_LEFT}   :
                     k == SC_RIGHT  ? {1'b1, IDX_RIGHT}  :
                     k == SC_FIRE   ? {1'b1, IDX_FIRE}   :
                     k == SC_BOMB   ? {1'b1, IDX_BOMB}   :
                     k == SC_START  ? {1'b1, IDX_START}  :
                     k == SC_SELECT ? {1'b1, IDX_SELECT} : 4'd0;
    end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: two-stage hps_io key event decoder to held-key bits with fire autorepeat
module ps2_key_decoder
    import scramble_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        clear_all,
    input  logic        autofire_en,
    input  logic [1:0]  autofire_rate,
    output logic [7:0]  keys,
    output logic        fire_out,
    output logic        key_event,
    output logic [2:0]  key_event_idx,
    output logic        key_event_pressed
);
    logic       tog_q;
    logic       s1_valid;
    key_evt_t   s1;
    logic       hit;
    logic [2:0] idx;
    logic       change;
    logic [7:0] keys_d;
    logic [19:0] cnt;
    logic [4:0] af_bit;
    scramble_keymap u_keymap (
        .code (s1.code),
        .ext  (s1.ext),
        .hit  (hit),
        .idx  (idx)
    );
    always_comb begin
        change = s1_valid & hit & (keys[idx] != s1.pressed) & ~clear_all;
        keys_d = clear_all ? 8'd0 :
                 change    ? (keys & ~(8'd1 << idx)) | (8'(s1.pressed) << idx) : keys;
        af_bit = AF_BASE + 5'(autofire_rate);
    end
    always_ff @(posedge clk_sys) begin
        tog_q <= ps2_key[10];
        if (reset) begin
            s1_valid          <= 1'b0;
            s1                <= '0;
            keys              <= 8'd0;
            key_event         <= 1'b0;
            key_event_idx     <= 3'd0;
            key_event_pressed <= 1'b0;
            cnt               <= 20'd0;
            fire_out          <= 1'b0;
        end else begin
            s1_valid  <= (ps2_key[10] != tog_q) & ~clear_all;
            s1        <= ps2_key[9:0];
            keys      <= keys_d;
            key_event <= change;
            if (change) begin
                key_event_idx     <= idx;
                key_event_pressed <= s1.pressed;
            end
            cnt      <= (keys_d[4] & ~keys[4]) ? 20'd0 : cnt + 20'd1;
            fire_out <= keys[4] & (~autofire_en | ~cnt[af_bit]);
        end
    end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench for the PS/2 key decoder
module tb_ps2_key_decoder;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic        clear_all = 1'b0;
    logic        autofire_en = 1'b0;
    logic [1:0]  autofire_rate = 2'd0;
    logic [7:0]  keys;
    logic        fire_out;
    logic        key_event;
    logic [2:0]  key_event_idx;
    logic        key_event_pressed;
    ps2_key_decoder dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .ps2_key           (ps2_key),
        .clear_all         (clear_all),
        .autofire_en       (autofire_en),
        .autofire_rate     (autofire_rate),
        .keys              (keys),
        .fire_out          (fire_out),
        .key_event         (key_event),
        .key_event_idx     (key_event_idx),
        .key_event_pressed (key_event_pressed)
    );
    always #5 clk_sys = ~clk_sys;
    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;
    typedef struct {
        int idx;
        int pressed;
        int keys;
        int cyc;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] m_keys = 8'd0;
    logic tgl = 1'b0;
    bit drop = 1'b0;
    logic [8:0] all_codes [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h011, 9'h016, 9'h01E};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int map_idx(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h175: return 0;
            9'h172: return 1;
            9'h16B: return 2;
            9'h174: return 3;
            9'h014: return 4;
            9'h011: return 5;
            9'h016: return 6;
            9'h01E: return 7;
            default: return -1;
        endcase
    endfunction
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask
    task automatic send(input logic ext, input logic pressed, input logic [7:0] code);
        int i;
        i = map_idx(ext, code);
        tgl = ~tgl;
        ps2_key = {tgl, pressed, ext, code};
        if (!drop && i >= 0 && m_keys[i] != pressed) begin
            m_keys[i] = pressed;
            sb.push_back('{i, int'(pressed), int'(m_keys), cyc + 2});
        end
        step();
    endtask
    task automatic settle_check(input string tag);
        repeat (3) step();
        check(tag, keys, m_keys);
        check({tag, "_pending"}, sb.size(), 0);
    endtask
    always @(negedge clk_sys) begin : mon
        exp_t e;
        if (key_event === 1'b1) begin
            if (sb.size() == 0) check("spurious_event", 1, 0);
            else begin
                e = sb.pop_front();
                check("evt_idx", key_event_idx, e.idx);
                check("evt_pressed", key_event_pressed, e.pressed);
                check("evt_keys", keys, e.keys);
                check("evt_cycle", cyc, e.cyc);
            end
        end
    end
    initial begin
        #2000000;
        check("watchdog", 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        int hi;
        int lo;
        step();
        step();
        check("rst_keys", keys, 0);
        check("rst_fire", fire_out, 0);
        check("rst_event", key_event, 0);
        check("rst_idx", key_event_idx, 0);
        check("rst_pressed", key_event_pressed, 0);
        reset = 1'b0;
        step();
        send(1, 1, 8'h6B);
        settle_check("left_press");
        send(0, 1, 8'h6B);
        settle_check("ext_mismatch");
        send(0, 1, 8'h14);
        settle_check("fire_press");
        check("fire_follow", fire_out, 1);
        send(0, 0, 8'h14);
        settle_check("fire_release");
        send(1, 1, 8'h75);
        send(0, 1, 8'h14);
        send(1, 1, 8'h75);
        settle_check("back_to_back");
        send(0, 1, 8'h5A);
        settle_check("unmapped");
        send(1, 0, 8'h72);
        settle_check("release_released");
        send(0, 0, 8'h14);
        settle_check("af_prep");
        autofire_en = 1'b1;
        autofire_rate = 2'd0;
        send(0, 1, 8'h14);
        check("af_before", fire_out, 0);
        step();
        step();
        check("af_first_shot", fire_out, 1);
        hi = 0;
        while (fire_out === 1'b1 && hi < 70000) begin
            hi++;
            step();
        end
        check("af_high_len", hi, 65536);
        lo = 0;
        repeat (16) begin
            if (fire_out === 1'b0) lo++;
            step();
        end
        check("af_low_hold", lo, 16);
        autofire_rate = 2'd1;
        step();
        check("af_rate_change", fire_out, 1);
        autofire_rate = 2'd0;
        step();
        check("af_rate_back", fire_out, 0);
        autofire_en = 1'b0;
        step();
        check("af_disabled", fire_out, 1);
        for (int i = 0; i < 8; i++) send(all_codes[i][8], 1, all_codes[i][7:0]);
        settle_check("all_held");
        send(0, 0, 8'h16);
        settle_check("start_release");
        drop = 1'b1;
        send(0, 1, 8'h16);
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        drop = 1'b0;
        m_keys = 8'd0;
        check("clear_keys", keys, 0);
        settle_check("clear_hold");
        check("clear_fire", fire_out, 0);
        clear_all = 1'b1;
        drop = 1'b1;
        send(1, 1, 8'h74);
        clear_all = 1'b0;
        drop = 1'b0;
        settle_check("clear_discard");
        send(1, 1, 8'h74);
        settle_check("after_clear");
        if (tgl) send(0, 1, 8'h00);
        drop = 1'b1;
        send(1, 1, 8'h72);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        drop = 1'b0;
        m_keys = 8'd0;
        settle_check("reset_discard");
        send(1, 1, 8'h72);
        settle_check("post_reset");
        check("final_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 clk_sys  in  1  system clock; all logic in this single domain.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ps2_key  in  11  key event from hps_io:
  - [7:0] scancode
  - [8] extended (E0)
  - [9] pressed
  - [10] toggle; the event is new when this bit changes.
REQ-004 clear_all  in  1  level; while high, all held keys are released (OSD open or focus loss).
REQ-005 autofire_en  in  1  enables fire autorepeat.
REQ-006 autofire_rate  in  2  selects autofire half-period: 2^(16+autofire_rate) clk_sys cycles.
REQ-007 keys  out  8  held state: 0 up, 1 down, 2 left, 3 right, 4 fire, 5 bomb, 6 start, 7 select.
REQ-008 fire_out  out  1  fire line to the game core, with autofire applied.
REQ-009 key_event  out  1  one-cycle pulse when a bit of keys changes because of ps2_key.
REQ-010 key_event_idx  out  3  keys bit index of that change; valid with key_event.
REQ-011 key_event_pressed  out  1  new value of that bit; valid with key_event.

Function
REQ-012 Scancode map:
  - up = E0 75, down = E0 72, left = E0 6B, right = E0 74
  - fire = 14 (non-extended, LCtrl), bomb = 11 (non-extended, LAlt)
  - start = 16 ("1"), select = 1E ("2")
  - the extended bit SHALL match exactly; any other code is unmapped.
REQ-013 Toggle detection: a new event SHALL be detected when ps2_key[10] differs from its value registered on the previous cycle.
REQ-014 Pipeline:
  - stage 1 (edge N) captures code, extended and pressed;
  - stage 2 (edge N+1) does the map lookup and updates keys, key_event, key_event_idx and key_event_pressed.
  - Latency is 2 cycles from the toggle change to registered outputs.
REQ-015 Throughput: toggles on consecutive cycles SHALL each be processed, in order, with no loss.
REQ-016 Unmapped code: no change to keys; no key_event.
REQ-017 Redundant event (press of a held key, or release of a released key, e.g. typematic repeat): keys unchanged; no key_event.
REQ-018 clear_all high: keys SHALL be 0 at the next edge and stay 0; no key_event is issued.
REQ-019 clear_all coincident with a stage-2 press: clear wins; keys = 0; no key_event.
REQ-020 Events whose toggle arrives while clear_all is high SHALL be discarded and not replayed afterwards.
REQ-021 Autofire counter:
  - free-running 20-bit counter;
  - cleared on the cycle keys[4] goes 0->1, so the first shot is immediate;
  - wraps modulo 2^20.
REQ-022 fire_out SHALL be registered and equal keys[4] AND (NOT autofire_en OR NOT cnt[16+autofire_rate]).
REQ-023 A change of autofire_rate mid-burst SHALL take effect on the next cycle without resetting the counter.

Reset
REQ-024 While reset is high:
  - keys = 0, fire_out = 0, key_event = 0, key_event_idx = 0, key_event_pressed = 0
  - counter = 0; stage-1 valid = 0.
REQ-025 On reset, the toggle history register SHALL load the current ps2_key[10], so no spurious event follows deassertion.
REQ-026 A reset asserted while an event is in the pipeline SHALL discard that event.

Structure
REQ-027 Package scramble_pkg SHALL hold:
  - the scancode/extended constants for the eight inputs;
  - the keys bit-index constants;
  - the autofire base exponent (16).
REQ-028 The combinational map lookup SHALL be a sub-module, scramble_keymap.
  - Inputs: code and extended.
  - Outputs: hit and idx[2:0].
REQ-029 No other sub-modules; no memories.

Verification
REQ-030 Press left: ps2_key = {~t, 1, 1, 8'h6B} at edge N -> keys = 8'h04 at N+2, key_event = 1, key_event_idx = 2, key_event_pressed = 1, all for one cycle.
REQ-031 Extended mismatch: press {toggle, 1, 0, 8'h6B} -> keys unchanged, no key_event. Then press 8'h14 with extended = 0 -> keys[4] = 1 and idx = 4.
REQ-032 Back-to-back events:
  - press up at cycle N and press fire at cycle N+1;
  - then repeat the press of up (typematic);
  - expect key_event at N+2 (idx 0) and N+3 (idx 4), then no event for the repeat.
REQ-033 Autofire: autofire_en = 1, autofire_rate = 0, fire held -> fire_out is high for 65536 cycles, low for 65536, then high again; with autofire_en = 0, fire_out follows keys[4].
REQ-034 clear_all and reset:
  - with keys = 8'hFF, assert clear_all together with a start press in stage 2 -> keys = 0, no event;
  - reset while ps2_key[10] = 1 -> no event after release.
